// File: rtl/decode_execute_unit_pkg.sv
// Shared encodings for the katp91 decode/execute slice: operator groups,
// binary and unary ALU operator codes, and flag bit positions.
package decode_execute_unit_pkg;

    typedef enum logic [3:0] {
        GRP_SPECIAL       = 4'h0,
        GRP_SPECIAL_LONG  = 4'h1,
        GRP_RJMP          = 4'h2,
        GRP_SFLAG         = 4'h3,
        GRP_UFLAG         = 4'h4,
        GRP_WRRMATH       = 4'h5,
        GRP_WRSMATH       = 4'h6,
        GRP_CRRMATH       = 4'h7,
        GRP_CRSMATH       = 4'h8,
        GRP_CRVMATH       = 4'h9,
        GRP_WRRMATH_MEM   = 4'hA,
        GRP_WRSMATH_STACK = 4'hB
    } group_e;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_ADC = 4'd2,
        OP_SBC = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_CMP = 4'd7
    } binop_e;

    typedef enum logic [3:0] {
        UOP_INC = 4'd0,
        UOP_DEC = 4'd1,
        UOP_NOT = 4'd2,
        UOP_NEG = 4'd3,
        UOP_SHL = 4'd4,
        UOP_SHR = 4'd5,
        UOP_ROL = 4'd6,
        UOP_ROR = 4'd7
    } unop_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

endpackage

// File: rtl/decode_execute_unit_exec_alu.sv
// Combinational 16/8-bit ALU: binary ops, unary ops and Z/N/V/C generation.
module exec_alu
    import decode_execute_unit_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [3:0]  i_operator,
    input  logic        i_unary,
    input  logic        i_byte_mode,
    input  logic        i_carry_in,
    output logic [15:0] o_result,
    output logic [3:0]  o_flags
);

    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [15:0] w_addA;
    logic [15:0] w_addB;
    logic [15:0] w_res;
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic [3:0]  w_msb;
    logic        w_ci;
    logic        w_isAdd;
    logic        w_isSub;
    logic        w_valid;
    logic        w_c;
    logic        w_v;

    // INC/DEC/NEG reuse the adder and subtractor so their C and V follow the add/sub rules.
    always_comb begin
        w_a     = i_byte_mode ? {8'h00, i_a[7:0]} : i_a;
        w_b     = i_byte_mode ? {8'h00, i_b[7:0]} : i_b;
        w_msb   = i_byte_mode ? 4'd7 : 4'd15;
        w_addA  = w_a;
        w_addB  = 16'h0000;
        w_ci    = 1'b0;
        w_isAdd = 1'b0;
        w_isSub = 1'b0;
        w_valid = 1'b1;
        w_res   = w_a;
        w_c     = 1'b0;
        w_v     = 1'b0;

        if (!i_unary) begin
            case (i_operator)
                OP_ADD:         begin w_isAdd = 1'b1; w_addB = w_b; end
                OP_SUB, OP_CMP: begin w_isSub = 1'b1; w_addB = w_b; end
                OP_ADC:         begin w_isAdd = 1'b1; w_addB = w_b; w_ci = i_carry_in; end
                OP_SBC:         begin w_isSub = 1'b1; w_addB = w_b; w_ci = i_carry_in; end
                OP_AND:         w_res = w_a & w_b;
                OP_OR:          w_res = w_a | w_b;
                OP_XOR:         w_res = w_a ^ w_b;
                default:        w_valid = 1'b0;
            endcase
        end else begin
            case (i_operator)
                UOP_INC: begin w_isAdd = 1'b1; w_addB = 16'h0001; end
                UOP_DEC: begin w_isSub = 1'b1; w_addB = 16'h0001; end
                UOP_NOT: w_res = ~w_a;
                UOP_NEG: begin w_isSub = 1'b1; w_addA = 16'h0000; w_addB = w_a; end
                UOP_SHL: begin w_res = w_a << 1; w_c = w_a[w_msb]; end
                UOP_SHR: begin w_res = w_a >> 1; w_c = w_a[0]; end
                UOP_ROL: begin w_res = (w_a << 1) | {15'h0000, i_carry_in}; w_c = w_a[w_msb]; end
                UOP_ROR: begin w_res = (w_a >> 1) | ({15'h0000, i_carry_in} << w_msb); w_c = w_a[0]; end
                default: w_valid = 1'b0;
            endcase
        end

        w_sum  = {1'b0, w_addA} + {1'b0, w_addB} + {16'h0000, w_ci};
        w_diff = {1'b0, w_addA} - {1'b0, w_addB} - {16'h0000, w_ci};

        // In byte mode the upper operand bits are zero, so bit 8 is the carry/borrow.
        if (w_isAdd) begin
            w_res = w_sum[15:0];
            w_c   = i_byte_mode ? w_sum[8] : w_sum[16];
            w_v   = (w_addA[w_msb] == w_addB[w_msb]) && (w_res[w_msb] != w_addA[w_msb]);
        end
        if (w_isSub) begin
            w_res = w_diff[15:0];
            w_c   = i_byte_mode ? w_diff[8] : w_diff[16];
            w_v   = (w_addA[w_msb] != w_addB[w_msb]) && (w_res[w_msb] != w_addA[w_msb]);
        end
        if (i_byte_mode) begin
            w_res[15:8] = 8'h00;
        end

        o_result        = w_valid ? w_res : w_a;
        o_flags         = 4'h0;
        o_flags[FLAG_Z] = w_valid && (w_res == 16'h0000);
        o_flags[FLAG_N] = w_valid && w_res[w_msb];
        o_flags[FLAG_V] = w_valid && w_v;
        o_flags[FLAG_C] = w_valid && w_c;
    end

endmodule

// File: rtl/decode_execute_unit.sv
// katp91 decode/execute slice: instruction register, field decode, ALU
// write-back, flags register and relative-branch condition check.
module decode_execute_unit
    import decode_execute_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] word_in,
    input  logic        exec,
    input  logic [15:0] reg_a,
    input  logic [15:0] reg_b,
    output logic [3:0]  group,
    output logic [3:0]  operator,
    output logic [2:0]  rg1,
    output logic [2:0]  rg2,
    output logic [7:0]  val,
    output logic [7:0]  flag_mask,
    output logic [15:0] rel_offset,
    output logic        taken,
    output logic [15:0] result,
    output logic        wb,
    output logic [7:0]  flags
);

    logic [15:0] r_ir;
    logic [15:0] r_result;
    logic        r_wb;
    logic [7:0]  r_flags;

    logic        w_isMath;
    logic        w_unary;
    logic        w_byteMode;
    logic        w_isCmp;
    logic [15:0] w_aluA;
    logic [15:0] w_aluB;
    logic [15:0] w_aluResult;
    logic [3:0]  w_aluFlags;
    logic [15:0] w_wbValue;

    always_comb begin
        group      = r_ir[15:12];
        operator   = 4'h0;
        rg1        = 3'd0;
        rg2        = 3'd0;
        val        = 8'h00;
        flag_mask  = 8'h00;
        rel_offset = 16'h0000;
        case (group)
            GRP_RJMP: begin
                operator   = {2'b00, r_ir[11:10]};
                rel_offset = {{6{r_ir[9]}}, r_ir[9:0]};
            end
            GRP_SFLAG, GRP_UFLAG: begin
                operator  = r_ir[11:8];
                flag_mask = r_ir[7:0];
            end
            GRP_CRVMATH: begin
                operator = {3'b000, r_ir[11]};
                rg1      = r_ir[10:8];
                val      = r_ir[7:0];
            end
            default: begin
                operator = r_ir[11:8];
                rg1      = r_ir[5:3];
                rg2      = r_ir[2:0];
                val      = r_ir[7:0];
            end
        endcase
    end

    // Operand routing: byte groups pick a register half by bit 0 of the register number.
    always_comb begin
        w_isMath   = (group >= GRP_WRRMATH) && (group <= GRP_CRVMATH);
        w_unary    = (group == GRP_WRSMATH) || (group == GRP_CRSMATH);
        w_byteMode = (group >= GRP_CRRMATH) && (group <= GRP_CRVMATH);
        w_isCmp    = !w_unary && (operator == OP_CMP);
        w_aluA     = w_byteMode ? {8'h00, (rg1[0] ? reg_a[15:8] : reg_a[7:0])} : reg_a;
        case (group)
            GRP_WRRMATH: w_aluB = reg_b;
            GRP_CRRMATH: w_aluB = {8'h00, (rg2[0] ? reg_b[15:8] : reg_b[7:0])};
            GRP_CRVMATH: w_aluB = {8'h00, val};
            default:     w_aluB = 16'h0000;
        endcase
        if (!w_byteMode) begin
            w_wbValue = w_aluResult;
        end else if (rg1[0]) begin
            w_wbValue = {w_aluResult[7:0], reg_a[7:0]};
        end else begin
            w_wbValue = {reg_a[15:8], w_aluResult[7:0]};
        end
    end

    exec_alu u_alu (
        .i_a         (w_aluA),
        .i_b         (w_aluB),
        .i_operator  (operator),
        .i_unary     (w_unary),
        .i_byte_mode (w_byteMode),
        .i_carry_in  (r_flags[FLAG_C]),
        .o_result    (w_aluResult),
        .o_flags     (w_aluFlags)
    );

    always_comb begin
        taken = 1'b0;
        if (group == GRP_RJMP) begin
            case (operator[1:0])
                2'd1:    taken = r_flags[FLAG_Z];
                2'd2:    taken = !r_flags[FLAG_Z];
                2'd3:    taken = r_flags[FLAG_C];
                default: taken = 1'b0;
            endcase
        end
    end

    // exec consumes the word latched before this edge, even when load is also high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir     <= 16'h0000;
            r_result <= 16'h0000;
            r_wb     <= 1'b0;
            r_flags  <= 8'h00;
        end else begin
            if (load) begin
                r_ir <= word_in;
            end
            if (exec) begin
                r_wb <= 1'b0;
                if (w_isMath) begin
                    r_result     <= w_wbValue;
                    r_wb         <= !w_isCmp;
                    r_flags[3:0] <= w_aluFlags;
                end else if (group == GRP_SFLAG) begin
                    r_flags <= r_flags | flag_mask;
                end else if (group == GRP_UFLAG) begin
                    r_flags <= r_flags & ~flag_mask;
                end
            end
        end
    end

    assign result = r_result;
    assign wb     = r_wb;
    assign flags  = r_flags;

endmodule

// File: tb/tb_decode_execute_unit.sv
// Self-checking bench for decode_execute_unit: directed steps followed by
// randomized instructions compared against an integer-arithmetic model.
module tb_decode_execute_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] word_in;
    logic        exec;
    logic [15:0] reg_a;
    logic [15:0] reg_b;
    logic [3:0]  group;
    logic [3:0]  operator;
    logic [2:0]  rg1;
    logic [2:0]  rg2;
    logic [7:0]  val;
    logic [7:0]  flag_mask;
    logic [15:0] rel_offset;
    logic        taken;
    logic [15:0] result;
    logic        wb;
    logic [7:0]  flags;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mIr, mResult, nIr, nResult;
    logic        mWb, nWb;
    logic [7:0]  mFlags, nFlags;

    decode_execute_unit dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .word_in    (word_in),
        .exec       (exec),
        .reg_a      (reg_a),
        .reg_b      (reg_b),
        .group      (group),
        .operator   (operator),
        .rg1        (rg1),
        .rg2        (rg2),
        .val        (val),
        .flag_mask  (flag_mask),
        .rel_offset (rel_offset),
        .taken      (taken),
        .result     (result),
        .wb         (wb),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int toSigned(input int x, input int w);
        return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
    endfunction

    // Reference ALU on plain integers: w is 8 or 16, flags returned as {C,V,N,Z}.
    task automatic aluModel(input int a, input int b, input int op, input bit un,
                            input int w, input bit cin, output int r, output logic [3:0] f);
        int  mask, half, x, y, ci, full, s;
        bit  doAdd, doSub, valid, c, v;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        r = a; c = 0; v = 0; valid = 1; doAdd = 0; doSub = 0; x = a; y = b; ci = 0;
        if (!un) begin
            case (op)
                0: doAdd = 1;
                1: doSub = 1;
                2: begin doAdd = 1; ci = int'(cin); end
                3: begin doSub = 1; ci = int'(cin); end
                4: r = a & b;
                5: r = a | b;
                6: r = a ^ b;
                7: doSub = 1;
                default: valid = 0;
            endcase
        end else begin
            case (op)
                0: begin doAdd = 1; y = 1; end
                1: begin doSub = 1; y = 1; end
                2: r = ~a & mask;
                3: begin doSub = 1; x = 0; y = a; end
                4: begin r = (a << 1) & mask; c = (a >= half); end
                5: begin r = a >> 1; c = (a % 2) == 1; end
                6: begin r = ((a << 1) | int'(cin)) & mask; c = (a >= half); end
                7: begin r = (a >> 1) + (cin ? half : 0); c = (a % 2) == 1; end
                default: valid = 0;
            endcase
        end
        if (doAdd) begin
            full = x + y + ci;
            r = full & mask;
            c = full > mask;
            s = toSigned(x, w) + toSigned(y, w) + ci;
            v = (s >= half) || (s < -half);
        end
        if (doSub) begin
            full = x - y - ci;
            r = full & mask;
            c = full < 0;
            s = toSigned(x, w) - toSigned(y, w) - ci;
            v = (s >= half) || (s < -half);
        end
        if (!valid) begin
            r = a;
            f = 4'h0;
        end else begin
            f = {c, v, (r >= half), (r == 0)};
        end
    endtask

    // Computes the model's post-edge state from its current state and the inputs.
    task automatic modelNext(input bit ld, input logic [15:0] w, input bit ex,
                             input logic [15:0] ra, input logic [15:0] rb);
        int          g, op, a, b, r;
        bit          un, byteOp;
        logic [2:0]  r1, r2;
        logic [3:0]  f;
        nIr = mIr; nResult = mResult; nWb = mWb; nFlags = mFlags;
        if (ld) nIr = w;
        if (ex) begin
            g = int'(mIr[15:12]);
            nWb = 1'b0;
            if (g == 3) nFlags = mFlags | mIr[7:0];
            if (g == 4) nFlags = mFlags & ~mIr[7:0];
            if (g >= 5 && g <= 9) begin
                un     = (g == 6) || (g == 8);
                byteOp = (g >= 7);
                op     = (g == 9) ? int'(mIr[11]) : int'(mIr[11:8]);
                r1     = (g == 9) ? mIr[10:8] : mIr[5:3];
                r2     = mIr[2:0];
                if (!byteOp) begin
                    a = int'(ra);
                    b = (g == 5) ? int'(rb) : 0;
                end else begin
                    a = r1[0] ? int'(ra[15:8]) : int'(ra[7:0]);
                    if (g == 7)      b = r2[0] ? int'(rb[15:8]) : int'(rb[7:0]);
                    else if (g == 9) b = int'(mIr[7:0]);
                    else             b = 0;
                end
                aluModel(a, b, op, un, byteOp ? 8 : 16, mFlags[3], r, f);
                if (!byteOp)    nResult = 16'(r);
                else if (r1[0]) nResult = 16'(r * 256 + int'(ra[7:0]));
                else            nResult = 16'(int'(ra[15:8]) * 256 + r);
                nFlags[3:0] = f;
                nWb = !(!un && op == 7);
            end
        end
    endtask

    task automatic checkOutput();
        int          g;
        logic [3:0]  eop;
        logic [2:0]  e1, e2;
        logic [7:0]  ev, efm;
        logic [15:0] erel;
        logic        et;
        g = int'(mIr[15:12]);
        eop = 4'h0; e1 = 3'd0; e2 = 3'd0; ev = 8'h00; efm = 8'h00; erel = 16'h0000; et = 1'b0;
        if (g == 2) begin
            eop  = 4'(mIr[11:10]);
            erel = 16'(int'(mIr[9:0]) - (mIr[9] ? 1024 : 0));
            case (mIr[11:10])
                2'd1: et = mFlags[0];
                2'd2: et = !mFlags[0];
                2'd3: et = mFlags[3];
                default: et = 1'b0;
            endcase
        end else if (g == 3 || g == 4) begin
            eop = mIr[11:8];
            efm = mIr[7:0];
        end else if (g == 9) begin
            eop = mIr[11] ? 4'd1 : 4'd0;
            e1  = mIr[10:8];
            ev  = mIr[7:0];
        end else begin
            eop = mIr[11:8];
            e1  = mIr[5:3];
            e2  = mIr[2:0];
            ev  = mIr[7:0];
        end
        compare("group",      16'(group),     16'(g));
        compare("operator",   16'(operator),  16'(eop));
        compare("rg1",        16'(rg1),       16'(e1));
        compare("rg2",        16'(rg2),       16'(e2));
        compare("val",        16'(val),       16'(ev));
        compare("flag_mask",  16'(flag_mask), 16'(efm));
        compare("rel_offset", rel_offset,     erel);
        compare("taken",      16'(taken),     16'(et));
        compare("result",     result,         mResult);
        compare("wb",         16'(wb),        16'(mWb));
        compare("flags",      16'(flags),     16'(mFlags));
    endtask

    task automatic applyStimulus(input bit ld, input logic [15:0] w, input bit ex,
                                 input logic [15:0] ra, input logic [15:0] rb);
        @(negedge clk);
        load = ld; word_in = w; exec = ex; reg_a = ra; reg_b = rb;
        modelNext(ld, w, ex, ra, rb);
        @(posedge clk);
        #1;
        mIr = nIr; mResult = nResult; mWb = nWb; mFlags = nFlags;
        checkOutput();
    endtask

    // Asserts reset between edges with load/exec active to show reset wins.
    task automatic applyReset(input logic [15:0] w);
        @(negedge clk);
        load = 1'b1; exec = 1'b1; word_in = w;
        #2 reset = 1'b1;
        #1;
        mIr = 16'h0000; mResult = 16'h0000; mWb = 1'b0; mFlags = 8'h00;
        compare("rst_async_flags", 16'(flags), 16'h0000);
        @(posedge clk);
        #1;
        compare("rst_group",  16'(group), 16'h0000);
        compare("rst_result", result,     16'h0000);
        compare("rst_wb",     16'(wb),    16'h0000);
        compare("rst_flags",  16'(flags), 16'h0000);
        checkOutput();
        @(negedge clk);
        reset = 1'b0; load = 1'b0; exec = 1'b0;
    endtask

    function automatic logic [15:0] pickReg();
        logic [15:0] edges [4];
        edges[0] = 16'h0000; edges[1] = 16'hFFFF; edges[2] = 16'h8000; edges[3] = 16'h7FFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return 16'($urandom);
    endfunction

    initial begin
        logic [15:0] w;
        reset = 1'b1; load = 1'b0; exec = 1'b0; word_in = 16'h0000; reg_a = 16'h0000; reg_b = 16'h0000;
        mIr = 16'h0000; mResult = 16'h0000; mWb = 1'b0; mFlags = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        compare("init_result", result,     16'h0000);
        compare("init_flags",  16'(flags), 16'h0000);
        compare("init_wb",     16'(wb),    16'h0000);
        checkOutput();
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(1, 16'h30F0, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 16'h0000, 1, 16'h0000, 16'h0000);
        compare("sflag_flags", 16'(flags), 16'h00F0);
        applyStimulus(1, 16'h4080, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 16'h0000, 1, 16'h0000, 16'h0000);
        compare("uflag_flags", 16'(flags), 16'h0070);

        applyStimulus(1, 16'h500A, 0, 16'h0000, 16'h0000);
        compare("add_rg1", 16'(rg1), 16'h0001);
        compare("add_rg2", 16'(rg2), 16'h0002);
        applyStimulus(0, 16'h0000, 1, 16'hFFFF, 16'h0001);
        compare("add_result", result,          16'h0000);
        compare("add_flags",  16'(flags[3:0]), 16'h0009);
        compare("add_wb",     16'(wb),         16'h0001);

        applyStimulus(1, 16'h9B05, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 16'h0000, 1, 16'h1203, 16'h0000);
        compare("crv_result", result,          16'h0D03);
        compare("crv_flags",  16'(flags[3:0]), 16'h0000);

        applyStimulus(1, 16'h5708, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 16'h0000, 1, 16'h0005, 16'h0005);
        compare("cmp_z",  16'(flags[0]), 16'h0001);
        compare("cmp_c",  16'(flags[3]), 16'h0000);
        compare("cmp_wb", 16'(wb),       16'h0000);

        applyStimulus(1, 16'h2600, 0, 16'h0000, 16'h0000);
        compare("rjmp_rel",   rel_offset, 16'hFE00);
        compare("rjmp_taken", 16'(taken), 16'h0001);
        applyStimulus(1, 16'h4001, 0, 16'h0000, 16'h0000);
        applyStimulus(1, 16'h2600, 1, 16'h0000, 16'h0000);
        compare("rjmp_nz_taken", 16'(taken), 16'h0000);

        applyReset(16'h5000);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                applyReset(16'($urandom));
            end else begin
                w = 16'($urandom);
                if ($urandom_range(0, 3) != 0) w[15:12] = 4'($urandom_range(2, 9));
                applyStimulus(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), pickReg(), pickReg());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_execute_unit.md
# decode_execute_unit

Instruction-decode and execute slice of the katp91 16-bit CPU. It latches a fetched instruction word and slices it into group, operator, register, immediate, flag-mask and branch fields. It performs 16-bit and 8-bit ALU operations on register operands supplied by the register file, and holds the flags register. It also evaluates relative-branch conditions against those flags.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- load  in  1  capture word_in into the instruction register.
- word_in  in  16  fetched instruction.
- exec  in  1  execute latched instruction: update result, wb and flags.
- reg_a  in  16  register-file value of rg1.
- reg_b  in  16  register-file value of rg2.
- group  out  4  decoded operator group.
- operator  out  4  decoded operator.
- rg1, rg2  out  3  register numbers; bits [2:1] select the 16-bit register, bit 0 selects the high byte in byte ops.
- val  out  8  immediate.
- flag_mask  out  8  SFLAG/UFLAG mask.
- rel_offset  out  16  sign-extended 10-bit branch offset.
- taken  out  1  RJMP condition true (combinational).
- result  out  16  registered write-back value.
- wb  out  1  registered: result must be written to rg1.
- flags  out  8  flags register: [0]Z, [1]N, [2]V, [3]C, [7:4] user.

## Operation
- Groups, from word[15:12]:
  - 0 SPECIAL, 1 SPECIAL_LONG, 2 RJMP, 3 SFLAG, 4 UFLAG, 5 WRRMATH, 6 WRSMATH, 7 CRRMATH.
  - 8 CRSMATH, 9 CRVMATH, A WRRMATH_MEM, B WRSMATH_STACK, C–F reserved, treated as no-op.
- Field slicing per group. Outputs not listed for a group read 0.
  - RJMP: operator={2'b00,word[11:10]}, rel=word[9:0].
  - SFLAG/UFLAG: operator=word[11:8], flag_mask=word[7:0].
  - CRVMATH: rg1=word[10:8], val=word[7:0], operator=word[11]?1:0.
  - All other groups: operator=word[11:8], rg1=word[5:3], rg2=word[2:0], val=word[7:0].
- Binary operators: 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 CMP. CMP computes like SUB.
- Unary operators, used by WRSMATH/CRSMATH: 0 INC, 1 DEC, 2 NOT, 3 NEG, 4 SHL, 5 SHR (logical), 6 ROL (through C), 7 ROR (through C).
- Any other operator code gives result = operand A with all four flags 0.
- Flag rules, with width w = 16 or 8:
  - Z: result is zero.
  - N: result msb.
  - C: for add, carry out of bit w-1; for sub, borrow (A<B unsigned); for NEG, A≠0; for shifts and rotates, the bit shifted out; for logic and NOT, 0.
  - V: two's-complement overflow for add/sub/INC/DEC/NEG; 0 otherwise.
- Word groups (5, 6):
  - A=reg_a; B=reg_b for group 5, 0 for group 6.
  - result=ALU out; flags[3:0] take the 16-bit flags.
- Byte groups (7, 8, 9):
  - A = byte of reg_a selected by rg1[0].
  - B = byte of reg_b selected by rg2[0] for group 7, or val for group 9.
  - The ALU operates on 8 bits.
  - result = rg1[0] ? {alu[7:0], reg_a[7:0]} : {reg_a[15:8], alu[7:0]}.
  - flags[3:0] take the 8-bit flags.
- wb=1 on exec of groups 5–9 unless operator is CMP. On any other exec, wb=0 and result holds.
- SFLAG: flags |= mask. UFLAG: flags &= ~mask. flags[7:4] change only through SFLAG/UFLAG.
- Branch conditions: taken = (group==2) and cond. cond is 0 always, 1 Z=1, 2 Z=0, 3 C=1.

## Timing
- Reset, asynchronous: instruction register 0 (decodes as SPECIAL op 0), result 0x0000, wb 0, flags 0x00.
- Decode outputs and taken are combinational from the instruction register and flags. They are valid in the cycle after load.
- Effects of exec are visible the cycle after the edge.
- load and exec asserted together: exec acts on the previously latched word, and the new word is latched at the same edge.
- Reset asserted mid-operation overrides any load or exec.

## Structure
- Shared package holds the group codes, operator codes and flag bit indices.
- One sub-module, exec_alu: combinational; inputs A, B, operator, unary, byte_mode, carry_in; outputs result and the 4 flags.
- Decode and branch check stay inline.

## Test plan
- Reset mid-run → flags 0x00, result 0x0000, wb 0, group 0.
- Load 0x500A (ADD, rg1=1, rg2=2), reg_a=0xFFFF, reg_b=0x0001, exec → result 0x0000, flags[3:0]=0x9 (Z and C set), wb 1.
- Load 0x9B05 (CRVMATH SUB, rg1=3, val=0x05), reg_a=0x1203, exec → result 0x0D03, flags[3:0]=0x0.
- Load 0x5708 (CMP), reg_a=reg_b=0x0005, exec → Z=1, C=0, wb 0.
- Load 0x30F0, exec → flags=0xF0. Then load 0x4080, exec → flags=0x70.
- Load 0x2600 (RJMP cond Z, rel 0x200) → rel_offset 0xFE00; taken=1 when Z=1, taken=0 when Z=0.
